// File: rtl/seg7_pkg.sv
// Shared constants and glyph encoding for the 7-segment scan driver.
// Segment bit order is {g,f,e,d,c,b,a}; all codes are active-low.
package seg7_pkg;

    localparam logic [6:0] SEG_OFF  = 7'h7F;
    localparam logic [6:0] SEG_DASH = 7'h3F;

    localparam logic [6:0] GLYPH_TBL [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Codes 10..15 render as a dash when hex glyphs are disabled.
    function automatic logic [6:0] seg7_glyph(input logic [3:0] nibble, input logic hex_mode);
        if (!hex_mode && (nibble > 4'd9)) begin
            return SEG_DASH;
        end
        return GLYPH_TBL[nibble];
    endfunction

endpackage

// File: rtl/seg7_glyph_lut.sv
// Combinational nibble to active-low segment encoder.
module seg7_glyph_lut #(
    parameter bit HEX_MODE = 1'b1
) (
    input  logic [3:0] nibble,
    output logic [6:0] seg_c
);
    import seg7_pkg::*;

    assign seg_c = seg7_glyph(nibble, HEX_MODE);

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver with a double-buffered
// frame, leading-zero blanking and per-slot anti-ghost blanking.
module seg7_scan_driver #(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned SLOT_CYC      = 50000,
    parameter int unsigned BLANK_CYC     = 16,
    parameter bit          HEX_MODE      = 1'b1,
    parameter bit          AN_ACTIVE_LOW = 1'b1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [4*NUM_DIGITS-1:0] digits_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    input  logic                    lz_blank_i,
    input  logic                    load_i,
    output logic                    pend_o,
    output logic                    frame_o,
    output logic [6:0]              seg_o,
    output logic                    dp_o,
    output logic [NUM_DIGITS-1:0]   an_o
);
    import seg7_pkg::*;

    localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
    localparam int unsigned CNT_W = $clog2(SLOT_CYC);
    localparam int unsigned DIG_W = 4 * NUM_DIGITS;
    localparam logic [NUM_DIGITS-1:0] AN_OFF = AN_ACTIVE_LOW ? '1 : '0;

    logic [CNT_W-1:0]      cnt_q;
    logic [IDX_W-1:0]      idx_q;
    logic                  frame_q;
    logic                  pend_q;
    logic [DIG_W-1:0]      pend_dig_q;
    logic [NUM_DIGITS-1:0] pend_dp_q;
    logic                  pend_lz_q;
    logic [DIG_W-1:0]      disp_dig_q;
    logic [NUM_DIGITS-1:0] disp_dp_q;
    logic                  disp_lz_q;
    logic [6:0]            seg_q;
    logic                  dp_q;
    logic [NUM_DIGITS-1:0] an_q;

    logic                  cnt_last;
    logic                  idx_last;
    logic                  in_blank;
    logic [3:0]            cur_nib;
    logic [6:0]            cur_glyph_c;
    logic                  cur_lz;
    logic [NUM_DIGITS-1:0] lz_vec;
    logic                  zero_run;
    logic [NUM_DIGITS-1:0] an_on;

    assign cnt_last = (cnt_q == CNT_W'(SLOT_CYC - 1));
    assign idx_last = (idx_q == IDX_W'(NUM_DIGITS - 1));
    assign in_blank = (cnt_q < CNT_W'(BLANK_CYC));
    assign cur_nib  = disp_dig_q[{idx_q, 2'b00} +: 4];
    assign cur_lz   = disp_lz_q & lz_vec[idx_q];
    assign an_on    = NUM_DIGITS'(1) << idx_q;

    // Slot counter and digit index.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            frame_q <= 1'b0;
        end else begin
            frame_q <= cnt_last & idx_last;
            if (cnt_last) begin
                cnt_q <= '0;
                idx_q <= idx_last ? '0 : idx_q + IDX_W'(1);
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // Pending/display buffers; the display only swaps during the frame_o cycle,
    // which lies inside the blanking window of digit 0.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend_q     <= 1'b0;
            pend_dig_q <= '0;
            pend_dp_q  <= '0;
            pend_lz_q  <= 1'b0;
            disp_dig_q <= '0;
            disp_dp_q  <= '0;
            disp_lz_q  <= 1'b0;
        end else begin
            if (load_i) begin
                pend_dig_q <= digits_i;
                pend_dp_q  <= dp_i;
                pend_lz_q  <= lz_blank_i;
            end
            if (frame_q) begin
                pend_q <= 1'b0;
                if (load_i) begin
                    disp_dig_q <= digits_i;
                    disp_dp_q  <= dp_i;
                    disp_lz_q  <= lz_blank_i;
                end else if (pend_q) begin
                    disp_dig_q <= pend_dig_q;
                    disp_dp_q  <= pend_dp_q;
                    disp_lz_q  <= pend_lz_q;
                end
            end else if (load_i) begin
                pend_q <= 1'b1;
            end
        end
    end

    // A digit is a leading zero when it and every more-significant nibble are zero.
    always_comb begin
        zero_run = 1'b1;
        lz_vec   = '0;
        for (int k = int'(NUM_DIGITS) - 1; k >= 0; k--) begin
            zero_run = zero_run & (disp_dig_q[4*k +: 4] == 4'h0);
            if (k != 0) begin
                lz_vec[k] = zero_run;
            end
        end
    end

    seg7_glyph_lut #(
        .HEX_MODE(HEX_MODE)
    ) u_glyph (
        .nibble(cur_nib),
        .seg_c (cur_glyph_c)
    );

    // Registered pin drivers.
    always_ff @(posedge clk_i) begin
        if (rst_i || in_blank) begin
            seg_q <= SEG_OFF;
            dp_q  <= 1'b1;
            an_q  <= AN_OFF;
        end else begin
            seg_q <= cur_lz ? SEG_OFF : cur_glyph_c;
            dp_q  <= ~disp_dp_q[idx_q];
            an_q  <= AN_ACTIVE_LOW ? ~an_on : an_on;
        end
    end

    assign pend_o  = pend_q;
    assign frame_o = frame_q;
    assign seg_o   = seg_q;
    assign dp_o    = dp_q;
    assign an_o    = an_q;

endmodule
